// File: rtl/imem_loader_pkg.sv
// ============================================================================
// Module  : imem_loader_pkg
// Brief   : Shared state encoding and defaults for the UART instruction loader.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef IMEMSIZE
`define IMEMSIZE 1024
`endif

package imem_loader_pkg;

    localparam int unsigned C_IMEMSIZE_DEFAULT = `IMEMSIZE;
    localparam logic [7:0]  C_SYNC_DEFAULT     = 8'hA5;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LEN0 = 3'd1,
        ST_LEN1 = 3'd2,
        ST_DATA = 3'd3,
        ST_CSUM = 3'd4,
        ST_DONE = 3'd5,
        ST_ERR  = 3'd6
    } state_t;

endpackage

`default_nettype wire

// File: rtl/imem_loader_asm.sv
// ============================================================================
// Module  : imem_loader_asm
// Brief   : Packs payload bytes little-endian into 32-bit words, one write pulse per word.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module imem_loader_asm (
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        in_valid,
    input  logic [7:0]  in_byte,
    output logic        word_last,
    output logic        we,
    output logic [31:0] waddr,
    output logic [31:0] wdata
);

    logic [1:0]  r_cnt;
    logic [23:0] r_shift;
    logic [29:0] r_widx;
    logic        r_we;
    logic [31:0] r_waddr;
    logic [31:0] r_wdata;

    assign word_last = in_valid && (r_cnt == 2'd3);
    assign we        = r_we;
    assign waddr     = r_waddr;
    assign wdata     = r_wdata;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt   <= 2'd0;
            r_shift <= 24'd0;
            r_widx  <= 30'd0;
            r_we    <= 1'b0;
            r_waddr <= 32'd0;
            r_wdata <= 32'd0;
        end else begin
            r_we <= 1'b0;
            // waddr/wdata are deliberately left alone on restart; they only move on a write
            if (clear) begin
                r_cnt  <= 2'd0;
                r_widx <= 30'd0;
            end else if (in_valid) begin
                r_cnt <= r_cnt + 2'd1;
                case (r_cnt)
                    2'd0:    r_shift[7:0]   <= in_byte;
                    2'd1:    r_shift[15:8]  <= in_byte;
                    2'd2:    r_shift[23:16] <= in_byte;
                    default: begin
                        r_we    <= 1'b1;
                        r_wdata <= {in_byte, r_shift};
                        r_waddr <= {r_widx, 2'b00};
                        r_widx  <= r_widx + 30'd1;
                    end
                endcase
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/imem_loader.sv
// ============================================================================
// Module  : imem_loader
// Brief   : Parses a SYNC/LEN/payload/XOR-checksum frame from a UART into instruction memory.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int unsigned IMEMSIZE = C_IMEMSIZE_DEFAULT,
    parameter logic [7:0]  SYNC     = C_SYNC_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        we,
    output logic [31:0] waddr,
    output logic [31:0] wdata,
    output logic        cpu_hold,
    output logic        done,
    output logic        error
);

    // Depths beyond the 16-bit length field can never be exceeded, so saturate.
    localparam logic [16:0] c_max_words = (IMEMSIZE > 32'd65535) ? 17'h1FFFF : 17'(IMEMSIZE);

    state_t      r_state;
    logic [15:0] r_len;
    logic [15:0] r_wcnt;
    logic [7:0]  r_csum;
    logic        r_done;
    logic        r_error;
    logic        r_hold;

    logic [15:0] w_n;
    logic        w_restart;
    logic        w_data_valid;
    logic        w_word_last;

    assign w_n          = {rx_data, r_len[7:0]};
    assign w_restart    = rx_valid && (rx_data == SYNC) &&
                          ((r_state == ST_IDLE) || (r_state == ST_ERR));
    assign w_data_valid = rx_valid && (r_state == ST_DATA);

    assign done     = r_done;
    assign error    = r_error;
    assign cpu_hold = r_hold;

    imem_loader_asm u_asm (
        .clk       (clk),
        .reset     (reset),
        .clear     (w_restart),
        .in_valid  (w_data_valid),
        .in_byte   (rx_data),
        .word_last (w_word_last),
        .we        (we),
        .waddr     (waddr),
        .wdata     (wdata)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_len   <= 16'd0;
            r_wcnt  <= 16'd0;
            r_csum  <= 8'd0;
            r_done  <= 1'b0;
            r_error <= 1'b0;
            r_hold  <= 1'b1;
        end else if (rx_valid) begin
            case (r_state)
                ST_IDLE, ST_ERR: begin
                    if (w_restart) begin
                        r_state <= ST_LEN0;
                        r_len   <= 16'd0;
                        r_wcnt  <= 16'd0;
                        r_csum  <= 8'd0;
                        r_error <= 1'b0;
                    end
                end
                ST_LEN0: begin
                    r_len[7:0] <= rx_data;
                    r_state    <= ST_LEN1;
                end
                ST_LEN1: begin
                    r_len[15:8] <= rx_data;
                    if (w_n == 16'd0) begin
                        r_state <= ST_CSUM;
                    end else if ({1'b0, w_n} > c_max_words) begin
                        r_state <= ST_ERR;
                        r_error <= 1'b1;
                    end else begin
                        r_state <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    r_csum <= r_csum ^ rx_data;
                    if (w_word_last) begin
                        r_wcnt <= r_wcnt + 16'd1;
                        if (r_wcnt == r_len - 16'd1) begin
                            r_state <= ST_CSUM;
                        end
                    end
                end
                ST_CSUM: begin
                    if (rx_data == r_csum) begin
                        r_state <= ST_DONE;
                        r_done  <= 1'b1;
                        r_hold  <= 1'b0;
                    end else begin
                        r_state <= ST_ERR;
                        r_error <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_imem_loader.sv
// ============================================================================
// Module  : tb_imem_loader
// Brief   : Directed self-checking bench for imem_loader.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_imem_loader;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  rx_data = 8'd0;
    logic        rx_valid = 1'b0;
    logic        we;
    logic [31:0] waddr;
    logic [31:0] wdata;
    logic        cpu_hold;
    logic        done;
    logic        error;

    int n_checks = 0;
    int n_err    = 0;

    logic [7:0]  fb[$];
    logic [31:0] log_a[$];
    logic [31:0] log_d[$];

    imem_loader #(.IMEMSIZE(1024), .SYNC(8'hA5)) dut (
        .clk      (clk),
        .reset    (reset),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .we       (we),
        .waddr    (waddr),
        .wdata    (wdata),
        .cpu_hold (cpu_hold),
        .done     (done),
        .error    (error)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (we) begin
            log_a.push_back(waddr);
            log_d.push_back(wdata);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic send_frame(input int gap);
        foreach (fb[i]) begin
            rx_data  = fb[i];
            rx_valid = 1'b1;
            @(negedge clk);
            if (gap > 0) begin
                rx_valid = 1'b0;
                repeat (gap) @(negedge clk);
            end
        end
        rx_valid = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        log_a.delete();
        log_d.delete();
    endtask

    task automatic chk_frame_a(input string tag);
        chk({tag, "_nwr"}, 32'(log_a.size()), 32'd2);
        if (log_a.size() == 2) begin
            chk({tag, "_a0"}, log_a[0], 32'h0);
            chk({tag, "_d0"}, log_d[0], 32'h0000_0013);
            chk({tag, "_a1"}, log_a[1], 32'h4);
            chk({tag, "_d1"}, log_d[1], 32'hC000_1073);
        end
        chk({tag, "_done"}, {31'd0, done}, 32'd1);
        chk({tag, "_hold"}, {31'd0, cpu_hold}, 32'd0);
        chk({tag, "_err"}, {31'd0, error}, 32'd0);
    endtask

    initial begin
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_we",    {31'd0, we},       32'd0);
        chk("rst_waddr", waddr,             32'd0);
        chk("rst_wdata", wdata,             32'd0);
        chk("rst_done",  {31'd0, done},     32'd0);
        chk("rst_error", {31'd0, error},    32'd0);
        chk("rst_hold",  {31'd0, cpu_hold}, 32'd1);

        // Valid two-word frame, back-to-back bytes
        fb = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
               8'h73, 8'h10, 8'h00, 8'hC0, 8'hB0};
        send_frame(0);
        repeat (2) @(negedge clk);
        chk_frame_a("fa");

        // Bytes after done are ignored
        fb = '{8'hA5, 8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h44};
        send_frame(0);
        repeat (2) @(negedge clk);
        chk("post_done_nwr",   32'(log_a.size()), 32'd2);
        chk("post_done_wdata", wdata, 32'hC000_1073);
        chk("post_done_done",  {31'd0, done}, 32'd1);

        // Bad checksum, then recovery by resending without reset
        do_reset();
        fb = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
               8'h73, 8'h10, 8'h00, 8'hC0, 8'h00};
        send_frame(0);
        repeat (2) @(negedge clk);
        chk("bad_nwr",   32'(log_a.size()), 32'd2);
        chk("bad_err",   {31'd0, error},    32'd1);
        chk("bad_done",  {31'd0, done},     32'd0);
        chk("bad_hold",  {31'd0, cpu_hold}, 32'd1);
        log_a.delete();
        log_d.delete();
        fb = '{8'h5A, 8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
               8'h73, 8'h10, 8'h00, 8'hC0, 8'hB0};
        send_frame(0);
        repeat (2) @(negedge clk);
        chk_frame_a("resend");

        // Leading junk, empty image
        do_reset();
        fb = '{8'h00, 8'hFF, 8'hA5, 8'h00, 8'h00, 8'h00};
        send_frame(0);
        repeat (2) @(negedge clk);
        chk("empty_done", {31'd0, done},     32'd1);
        chk("empty_hold", {31'd0, cpu_hold}, 32'd0);
        chk("empty_nwr",  32'(log_a.size()), 32'd0);

        // Length one past the memory depth
        do_reset();
        fb = '{8'hA5, 8'h01, 8'h04};
        send_frame(0);
        chk("ovf_err",  {31'd0, error}, 32'd1);
        chk("ovf_done", {31'd0, done},  32'd0);
        repeat (3) @(negedge clk);
        chk("ovf_nwr",  32'(log_a.size()), 32'd0);

        // Single word at the odd byte pattern, checks byte order
        do_reset();
        fb = '{8'hA5, 8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h22};
        send_frame(0);
        repeat (2) @(negedge clk);
        chk("one_nwr",  32'(log_a.size()), 32'd1);
        chk("one_d0",   (log_d.size() > 0) ? log_d[0] : 32'hXXXX_XXXX, 32'hDEAD_BEEF);
        chk("one_done", {31'd0, done}, 32'd1);

        // Reset mid-word, asserted together with a valid byte
        do_reset();
        fb = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h73, 8'h10};
        send_frame(0);
        rx_data  = 8'h00;
        rx_valid = 1'b1;
        reset    = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
        reset    = 1'b0;
        chk("mid_we",    {31'd0, we},       32'd0);
        chk("mid_waddr", waddr,             32'd0);
        chk("mid_wdata", wdata,             32'd0);
        chk("mid_hold",  {31'd0, cpu_hold}, 32'd1);
        rx_data  = 8'hC0;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("mid_nwr",   32'(log_a.size()), 32'd1);
        chk("mid_done",  {31'd0, done},     32'd0);
        log_a.delete();
        log_d.delete();
        fb = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
               8'h73, 8'h10, 8'h00, 8'hC0, 8'hB0};
        send_frame(0);
        repeat (2) @(negedge clk);
        chk_frame_a("after_mid");

        // Same frame with sparse rx_valid
        do_reset();
        send_frame(9);
        repeat (2) @(negedge clk);
        chk_frame_a("sparse");

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
